// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared access-size encodings, FSM state codes and alignment helper
//          for the data memory interface.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [1:0] SZ_WORD     = 2'b00;
    localparam logic [1:0] SZ_HALF     = 2'b01;
    localparam logic [1:0] SZ_BYTE     = 2'b10;
    localparam logic [1:0] SZ_WORD_ALT = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    // Bytes are always aligned; halves need an even address; words (either code) need a multiple of 4.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: return lo[0];
            SZ_BYTE: return 1'b0;
            default: return (lo != 2'b00);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_steer.sv
// ============================================================================
// Module : byte_lane_steer
// Brief  : Little-endian byte-enable and store-data lane replication.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_lane_steer
    import mem_pkg::*;
(
    input  logic [1:0]  i_storecontrol,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_byteenable,
    output logic [31:0] o_writedata
);

    always_comb begin
        o_byteenable = 4'b1111;
        o_writedata  = i_wdata;
        case (i_storecontrol)
            SZ_HALF: begin
                o_byteenable = 4'b0011 << i_addr_lo;
                o_writedata  = {2{i_wdata[15:0]}};
            end
            SZ_BYTE: begin
                o_byteenable = 4'b0001 << i_addr_lo;
                o_writedata  = {4{i_wdata[7:0]}};
            end
            default: begin
                o_byteenable = 4'b1111;
                o_writedata  = i_wdata;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_interface.sv
// ============================================================================
// Module : data_mem_interface
// Brief  : Datapath load/store port to word-addressed waitrequest bus bridge
//          with stall generation, load-data latch and access timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_interface
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  storecontrol,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_out,
    output logic        stall,
    output logic        misalign,
    output logic        bus_error,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam int             CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [31:0]        r_addr;
    logic               r_rd;
    logic               r_wr;
    logic [3:0]         r_be;
    logic [31:0]        r_wd;

    logic               w_req;
    logic               w_misalign;
    logic               w_launch;
    logic [3:0]         w_be;
    logic [31:0]        w_wd;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_timeout;

    byte_lane_steer u_steer (
        .i_storecontrol (storecontrol),
        .i_addr_lo      (addr[1:0]),
        .i_wdata        (wdata),
        .o_byteenable   (w_be),
        .o_writedata    (w_wd)
    );

    assign w_req      = req_read | req_write;
    assign w_misalign = w_req & is_misaligned(storecontrol, addr[1:0]);
    assign w_launch   = (r_state == ST_IDLE) & w_req & ~w_misalign;

    // Counter saturates so a disabled timeout can sit in ACCESS forever without wrapping.
    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && avm_waitrequest && (w_cnt_inc == c_TIMEOUT);

    // Gated by reset so the datapath is released while the bridge is held in reset.
    assign stall          = reset & (w_launch | (r_state == ST_ACCESS));
    assign misalign       = w_misalign;
    assign rdata_out      = r_rdata;
    assign bus_error      = r_err;
    assign avm_address    = r_addr;
    assign avm_read       = r_rd;
    assign avm_write      = r_wr;
    assign avm_byteenable = r_be;
    assign avm_writedata  = r_wd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_be    <= '0;
            r_wd    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_addr  <= {addr[31:2], 2'b00};
                        r_wr    <= req_write;
                        r_rd    <= ~req_write;
                        r_be    <= req_write ? w_be : 4'b1111;
                        if (req_write) begin
                            r_wd <= w_wd;
                        end
                        r_cnt   <= '0;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!avm_waitrequest) begin
                        if (r_rd) begin
                            r_rdata <= avm_readdata;
                        end
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_cnt   <= w_cnt_inc;
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_interface.sv
// ============================================================================
// Module : tb_data_mem_interface
// Brief  : Self-checking bench for data_mem_interface (cycle model + directed vectors).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_interface;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  storecontrol = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata_out;
    logic        stall;
    logic        misalign;
    logic        bus_error;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;

    always #5 clk = ~clk;

    data_mem_interface #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_read        (req_read),
        .req_write       (req_write),
        .storecontrol    (storecontrol),
        .addr            (addr),
        .wdata           (wdata),
        .rdata_out       (rdata_out),
        .stall           (stall),
        .misalign        (misalign),
        .bus_error       (bus_error),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: what the bus and datapath must see this cycle.
    bit          m_busy, m_done, m_rd, m_wr, m_err;
    int          m_to;
    logic [31:0] m_addr, m_wd, m_rdata;
    logic [3:0]  m_be;
    bit          t_req, t_mis, t_launch;
    int          t_size;

    initial begin
        m_busy = 0; m_done = 0; m_rd = 0; m_wr = 0; m_err = 0; m_to = 0;
        m_addr = '0; m_wd = '0; m_rdata = '0; m_be = '0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            m_busy = 0; m_done = 0; m_rd = 0; m_wr = 0; m_err = 0; m_to = 0;
            m_addr = '0; m_wd = '0; m_rdata = '0; m_be = '0;
        end
        t_req    = req_read || req_write;
        t_size   = (storecontrol == 2'b01) ? 2 : (storecontrol == 2'b10) ? 1 : 4;
        t_mis    = t_req && ((addr % t_size) != 0);
        t_launch = reset && !m_busy && !m_done && t_req && !t_mis;

        check("misalign",   32'(misalign),       32'(t_mis));
        check("stall",      32'(stall),          32'(t_launch || m_busy));
        check("bus_error",  32'(bus_error),      32'(m_err));
        check("avm_read",   32'(avm_read),       32'(m_rd));
        check("avm_write",  32'(avm_write),      32'(m_wr));
        check("byteenable", 32'(avm_byteenable), 32'(m_be));
        check("address",    avm_address,         m_addr);
        check("writedata",  avm_writedata,       m_wd);
        check("rdata_out",  rdata_out,           m_rdata);

        if (reset) begin
            if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                if (!avm_waitrequest) begin
                    if (m_rd) m_rdata = avm_readdata;
                    m_busy = 0; m_done = 1; m_rd = 0; m_wr = 0;
                end else begin
                    m_to++;
                    if (TO != 0 && m_to >= TO) begin
                        m_busy = 0; m_done = 1; m_rd = 0; m_wr = 0;
                        m_err = 1; m_rdata = '0;
                    end
                end
            end else if (t_launch) begin
                m_busy = 1; m_to = 0;
                m_addr = addr & ~32'd3;
                m_wr   = req_write;
                m_rd   = !req_write;
                if (req_write) begin
                    m_be = 4'((((1 << t_size) - 1) << (addr % 4)) & 15);
                    m_wd = (t_size == 4) ? wdata :
                           (t_size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 :
                                           (wdata & 32'hFF) * 32'h0101_0101;
                end else begin
                    m_be = 4'hF;
                end
            end
        end
    end

    // Drives one request and returns during its commit (DONE) cycle, or during the
    // first cycle when no access is launched.
    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int nwait, input logic [31:0] rdv,
                           output int n_stall, output int n_strobe,
                           output logic [3:0] c_be, output logic [31:0] c_wd,
                           output logic [31:0] c_addr, output logic c_wr, output logic c_mis);
        bit finished = 0;
        n_stall = 0; n_strobe = 0; c_be = '0; c_wd = '0; c_addr = '0; c_wr = 0; c_mis = 0;
        req_read = rd; req_write = wr; storecontrol = sz; addr = a; wdata = wd;
        avm_readdata = rdv; avm_waitrequest = (nwait > 0);
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (c == 0) c_mis = misalign;
            if (avm_read || avm_write) begin
                if (n_strobe == 0) begin
                    c_be = avm_byteenable; c_wd = avm_writedata; c_addr = avm_address; c_wr = avm_write;
                end
                n_strobe++;
            end
            if (stall) begin
                n_stall++;
            end else begin
                finished = 1;
                break;
            end
            @(posedge clk); #1;
            avm_waitrequest = (c < nwait);
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL txn_bound: stall never released, got %0d cycles expected fewer than 64", n_stall);
        end
    endtask

    task automatic end_txn();
        @(posedge clk); #1;
        req_read = 0; req_write = 0;
    endtask

    int          ns, nst;
    logic [3:0]  cbe;
    logic [31:0] cwd, cad;
    logic        cwr, cmis;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_strobes", 32'({avm_read, avm_write}), 0);
        check("rst_be", 32'(avm_byteenable), 0);
        check("rst_rdata", rdata_out, 0);
        check("rst_err", 32'(bus_error), 0);
        reset = 1;
        @(posedge clk); #1;

        // sw, zero wait
        run_txn(0, 1, 2'b00, 32'h100, 32'h1122_3344, 0, 0, ns, nst, cbe, cwd, cad, cwr, cmis);
        check("sw_stall", 32'(ns), 2);
        check("sw_strobe", 32'(nst), 1);
        check("sw_be", 32'(cbe), 32'hF);
        check("sw_data", cwd, 32'h1122_3344);
        check("sw_addr", cad, 32'h100);
        end_txn();

        // sb to top lane
        run_txn(0, 1, 2'b10, 32'h103, 32'h0000_00AB, 0, 0, ns, nst, cbe, cwd, cad, cwr, cmis);
        check("sb_be", 32'(cbe), 32'h8);
        check("sb_data", cwd, 32'hABAB_ABAB);
        check("sb_addr", cad, 32'h100);
        end_txn();

        // lw with 3 wait cycles
        run_txn(1, 0, 2'b00, 32'h200, 32'h0, 3, 32'hCAFE_F00D, ns, nst, cbe, cwd, cad, cwr, cmis);
        check("lw_stall", 32'(ns), 5);
        check("lw_rdata", rdata_out, 32'hCAFE_F00D);
        check("lw_be", 32'(cbe), 32'hF);
        check("lw_wr", 32'(cwr), 0);
        end_txn();

        // misaligned lw
        run_txn(1, 0, 2'b00, 32'h202, 32'h0, 0, 32'h1234_5678, ns, nst, cbe, cwd, cad, cwr, cmis);
        check("mis_flag", 32'(cmis), 1);
        check("mis_stall", 32'(ns), 0);
        check("mis_strobe", 32'(nst), 0);
        end_txn();

        // sh upper half, legal
        run_txn(0, 1, 2'b01, 32'h202, 32'h0000_1234, 0, 0, ns, nst, cbe, cwd, cad, cwr, cmis);
        check("sh_mis", 32'(cmis), 0);
        check("sh_be", 32'(cbe), 32'hC);
        check("sh_data", cwd, 32'h1234_1234);
        check("sh_stall", 32'(ns), 2);
        end_txn();

        // read+write together behaves as a byte write
        run_txn(1, 1, 2'b10, 32'h301, 32'h0000_005A, 1, 0, ns, nst, cbe, cwd, cad, cwr, cmis);
        check("rw_wr", 32'(cwr), 1);
        check("rw_be", 32'(cbe), 32'h2);
        check("rw_data", cwd, 32'h5A5A_5A5A);
        check("rw_stall", 32'(ns), 3);
        end_txn();

        // waitrequest stuck high -> timeout
        run_txn(1, 0, 2'b00, 32'h400, 32'h0, 1000, 32'hFFFF_FFFF, ns, nst, cbe, cwd, cad, cwr, cmis);
        check("to_stall", 32'(ns), 17);
        check("to_err", 32'(bus_error), 1);
        check("to_rdata", rdata_out, 0);
        end_txn();
        avm_waitrequest = 0;

        // bus_error is sticky across later successful accesses
        run_txn(0, 1, 2'b00, 32'h104, 32'hDEAD_BEEF, 0, 0, ns, nst, cbe, cwd, cad, cwr, cmis);
        check("sticky_stall", 32'(ns), 2);
        check("sticky_err", 32'(bus_error), 1);
        end_txn();

        // reset in the middle of an access
        req_read = 1; storecontrol = 2'b00; addr = 32'h500; avm_waitrequest = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        #1;
        check("arst_read", 32'(avm_read), 0);
        check("arst_stall", 32'(stall), 0);
        check("arst_err", 32'(bus_error), 0);
        req_read = 0; avm_waitrequest = 0;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        run_txn(0, 1, 2'b00, 32'h108, 32'h0102_0304, 0, 0, ns, nst, cbe, cwd, cad, cwr, cmis);
        check("post_stall", 32'(ns), 2);
        check("post_data", cwd, 32'h0102_0304);
        end_txn();

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
